// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_RESUME    = 2'd3
  } state_t;

  localparam int ADDR_W        = 32;
  localparam int WORD_W        = 32;
  localparam int OFFSET_W      = 5;
  localparam int WORD_SEL_W    = 3;
  localparam int LINE_W        = 256;
  localparam int DEF_NUM_LINES = 32;

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines);
    return ADDR_W - OFFSET_W - $clog2(num_lines);
  endfunction

  localparam int INDEX_W = index_w(DEF_NUM_LINES);
  localparam int TAG_W   = tag_w(DEF_NUM_LINES);

endpackage

// File: rtl/dcache_sram.sv
// Tag and data arrays: one shared index, synchronous write, asynchronous read.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_BITS = LINE_W,
  parameter int TAG_BITS  = TAG_W,
  parameter int IDX_BITS  = INDEX_W
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [IDX_BITS-1:0]  i_idx,
  input  logic [TAG_BITS-1:0]  i_tag,
  input  logic [LINE_BITS-1:0] i_line,
  output logic [TAG_BITS-1:0]  o_tag,
  output logic [LINE_BITS-1:0] o_line
);

  logic [TAG_BITS-1:0]  r_tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data_mem [NUM_LINES];

  // array write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag_mem[i_idx]  <= i_tag;
      r_data_mem[i_idx] <= i_line;
    end
  end

  assign o_tag  = r_tag_mem[i_idx];
  assign o_line = r_data_mem[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller with a blocking miss FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_BITS = LINE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_memread_i,
  input  logic                 cpu_memwrite_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
`ifdef DCACHE_STATS_EN
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o,
`endif
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_data_i
);

  localparam int IDX_W = index_w(NUM_LINES);
  localparam int TG_W  = tag_w(NUM_LINES);

  state_t                r_state;
  state_t                w_next;
  logic [NUM_LINES-1:0]  r_valid;
  logic [NUM_LINES-1:0]  r_dirty;
  logic [IDX_W-1:0]      w_idx;
  logic [TG_W-1:0]       w_tag;
  logic [TG_W-1:0]       w_rd_tag;
  logic [WORD_SEL_W-1:0] w_word;
  logic [LINE_BITS-1:0]  w_rd_line;
  logic [LINE_BITS-1:0]  w_wr_line;
  logic                  w_we;
  logic                  w_access;
  logic                  w_hit;
  logic                  w_unused;

  assign w_idx    = cpu_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
  assign w_tag    = cpu_addr_i[ADDR_W-1:IDX_W+OFFSET_W];
  assign w_word   = cpu_addr_i[OFFSET_W-1:2];
  assign w_unused = ^cpu_addr_i[1:0];
  assign w_access = cpu_memread_i | cpu_memwrite_i;
  assign w_hit    = r_valid[w_idx] && (w_rd_tag == w_tag);

  assign cpu_data_o = w_rd_line[{w_word, 5'b00000} +: WORD_W];
  assign mem_data_o = w_rd_line;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_BITS  (TG_W),
    .IDX_BITS  (IDX_W)
  ) u_sram (
    .i_clk  (clk_i),
    .i_we   (w_we),
    .i_idx  (w_idx),
    .i_tag  (w_tag),
    .i_line (w_wr_line),
    .o_tag  (w_rd_tag),
    .o_line (w_rd_line)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state, memory handshake and array write control
  always_comb begin
    w_next      = r_state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0000_0000;
    w_we        = 1'b0;
    w_wr_line   = w_rd_line;
    case (r_state)
      ST_IDLE: begin
        if (w_access && w_hit) begin
          if (cpu_memwrite_i) begin
            w_we = 1'b1;
            w_wr_line[{w_word, 5'b00000} +: WORD_W] = cpu_data_i;
          end else begin
            w_we = 1'b0;
          end
        end else if (w_access) begin
          cpu_stall_o = 1'b1;
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? ST_WRITEBACK : ST_ALLOCATE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {w_rd_tag, w_idx, 5'b00000};
        if (mem_ack_i) begin
          w_next = ST_ALLOCATE;
        end else begin
          w_next = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {w_tag, w_idx, 5'b00000};
        if (mem_ack_i) begin
          w_we      = 1'b1;
          w_wr_line = mem_data_i;
          w_next    = ST_RESUME;
        end else begin
          w_next = ST_ALLOCATE;
        end
      end
      ST_RESUME: begin
        cpu_stall_o = 1'b1;
        w_next      = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // valid and dirty flags; the only cache state cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= {NUM_LINES{1'b0}};
      r_dirty <= {NUM_LINES{1'b0}};
    end else if ((r_state == ST_IDLE) && w_access && w_hit && cpu_memwrite_i) begin
      r_dirty[w_idx] <= 1'b1;
    end else if ((r_state == ST_ALLOCATE) && mem_ack_i) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  // access counters; a retried access after a fill lands in the hit count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else if ((r_state == ST_IDLE) && w_access) begin
      if (w_hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
